shift_issue_queue: RTL and testbench

SHIFT_ISSUE_QUEUE -- requirements
Module: shift_issue_queue

---
 rtl/shift_issue_queue.sv | 98 +++++++++
 tb/tb_shift_issue_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_queue.sv
// Shift issue queue: a small register FIFO of shift requests feeding an external
// combinational shifter, with a registered, back-pressurable result stage.
module shift_issue_queue #(
    parameter  int WIDTH       = 32,
    parameter  int DEPTH       = 4,
    localparam int SHAMT_WIDTH = $clog2(WIDTH),
    localparam int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic                   in_shope,
    output logic [WIDTH-1:0]       sh_i_1,
    output logic [SHAMT_WIDTH-1:0] sh_shamt,
    output logic                   sh_shope,
    output logic                   sh_enable,
    input  logic [WIDTH-1:0]       sh_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_WIDTH-1:0]   count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       data_q  [DEPTH];
    logic [SHAMT_WIDTH-1:0] shamt_q [DEPTH];
    logic                   shope_q [DEPTH];

    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic                   head_valid;
    logic                   push;
    logic                   pop;

    // Handshake decode: a pop is exactly a load of the result register.
    always_comb begin
        in_ready   = (count < CNT_WIDTH'(DEPTH));
        head_valid = (count != '0);
        push       = in_valid && in_ready;
        pop        = head_valid && (!out_valid || out_ready);
    end

    // Present the head entry to the shifter, zeroed when the queue is empty.
    always_comb begin
        sh_enable = head_valid;
        sh_i_1    = '0;
        sh_shamt  = '0;
        sh_shope  = 1'b0;
        if (head_valid) begin
            sh_i_1   = data_q[rd_ptr];
            sh_shamt = shamt_q[rd_ptr];
            sh_shope = shope_q[rd_ptr];
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr]  <= in_data;
            shamt_q[wr_ptr] <= in_shamt;
            shope_q[wr_ptr] <= in_shope;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            if (push && !pop)
                count <= count + CNT_WIDTH'(1);
            else if (pop && !push)
                count <= count - CNT_WIDTH'(1);
        end
    end

    // Result register: capture the shifter output on pop, drop valid when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sh_o;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed and randomised checks of shift_issue_queue against hand-computed
// values and a reference shift model; the external shifter is modelled here.
module tb_shift_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_shope;
    logic [31:0] sh_i_1;
    logic [4:0]  sh_shamt;
    logic        sh_shope;
    logic        sh_enable;
    logic [31:0] sh_o;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    shift_issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_shope  (in_shope),
        .sh_i_1    (sh_i_1),
        .sh_shamt  (sh_shamt),
        .sh_shope  (sh_shope),
        .sh_enable (sh_enable),
        .sh_o      (sh_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    // External combinational shifter.
    assign sh_o = sh_shope ? (sh_i_1 << sh_shamt) : (sh_i_1 >> sh_shamt);

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic op);
        return op ? (d << s) : (d >> s);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
        in_valid = v;
        in_data  = d;
        in_shamt = s;
        in_shope = op;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int unsigned sent;
    int unsigned recvd;
    int unsigned cyc;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #3;
        check("rst_count",     count,     0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_sh_enable", sh_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_sh_i_1",    sh_i_1,    0);
        #9;
        rst_n = 1'b1;
        step();

        // Single left shift: 0xF0 << 4.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_00F0, 5'd4, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("single_sh_enable", sh_enable, 1);
        check("single_sh_i_1",    sh_i_1,    32'h0000_00F0);
        check("single_sh_shamt",  sh_shamt,  4);
        check("single_sh_shope",  sh_shope,  1);
        check("single_count1",    count,     1);
        check("single_out_valid0", out_valid, 0);
        step();
        check("single_out_valid", out_valid, 1);
        check("single_out_data",  out_data,  32'h0000_0F00);
        check("single_count0",    count,     0);
        check("single_sh_idle",   sh_enable, 0);
        step();
        check("single_drained",   out_valid, 0);
        check("single_hold",      out_data,  32'h0000_0F00);

        // Right-shift boundaries.
        drive(1'b1, 32'h8000_0000, 5'd31, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("rshift31", out_data, 32'h0000_0001);
        drive(1'b1, 32'h1234_5678, 5'd0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("rshift0", out_data, 32'h1234_5678);
        drive(1'b1, 32'h0000_0003, 5'd31, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("lshift31", out_data, 32'h8000_0000);
        step();

        // Backpressure: five pushes of 1..5 << 1 with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 5'd1, 1'b1);
            step();
        end
        check("bp_count",     count,     4);
        check("bp_in_ready",  in_ready,  0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_data",  out_data,  32'h2);
        drive(1'b1, 32'hFF, 5'd1, 1'b1);
        step();
        check("bp_refused_count", count,    4);
        check("bp_stable_data",   out_data, 32'h2);
        // Full with simultaneous pop: the pop must not open in_ready this cycle.
        out_ready = 1'b1;
        check("full_simul_ready", in_ready, 0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("full_simul_count", count,    3);
        check("full_simul_ready_after", in_ready, 1);
        check("bp_res2", out_data, 32'h4);
        step();
        check("bp_res3", out_data, 32'h6);
        step();
        check("bp_res4", out_data, 32'h8);
        step();
        check("bp_res5", out_data, 32'hA);
        check("bp_empty", count, 0);
        step();
        check("bp_no_extra", out_valid, 0);

        // Random streaming against the reference model.
        sent  = 0;
        recvd = 0;
        cyc   = 0;
        while ((sent < 100 || recvd < 100) && cyc < 3000) begin
            if (sent < 100 && $urandom_range(0, 1) == 1)
                drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else
                drive(1'b0, '0, '0, 1'b0);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_data, in_shamt, in_shope));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("stream_data", out_data, exp_v);
                end
                recvd++;
            end
            step();
            cyc++;
        end
        drive(1'b0, '0, '0, 1'b0);
        check("stream_received", recvd, 100);
        check("stream_count_end", count, 0);

        // Asynchronous reset with queued and held results.
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i + 16), 5'd2, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        check("pre_rst_count", count,     3);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",     count,     0);
        check("arst_out_valid", out_valid, 0);
        check("arst_sh_enable", sh_enable, 0);
        check("arst_in_ready",  in_ready,  1);
        check("arst_out_data",  out_data,  0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0003, 5'd2, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("post_rst_count", count,  1);
        check("post_rst_head",  sh_i_1, 32'h3);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data",  out_data,  32'hC);
        check("post_rst_empty", count,     0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
